// File: rtl/uart_frame_ctrl_pkg.sv
// uart_frame_ctrl_pkg: shared FSM states and watchdog preset arithmetic for the frame controller
package uart_frame_ctrl_pkg;
  typedef enum logic [1:0] {S_OFF, S_IDLE, S_RECV, S_CLOSE} state_e;
  localparam int PROD_W = 12;
  function automatic logic [PROD_W-1:0] idle_bits(input logic [7:0] chars, input logic [3:0] bits);
    return PROD_W'(chars) * PROD_W'(bits);
  endfunction
endpackage

// File: rtl/uart_frame_ctrl_baud_tick.sv
// uart_frame_ctrl_baud_tick: one-cycle tick every div_i clocks while enabled, phase restarts on enable
module uart_frame_ctrl_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q;
  assign tick_o = en_i && (cnt_q == div_i - 1'b1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= (!en_i || tick_o) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: delimits UART RX bytes into idle-gap frames using an external watchdog
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_baud_div,
  input  logic [3:0]       cfg_bits_char,
  input  logic [7:0]       cfg_idle_chars,
  input  logic             rx_valid,
  input  logic             rx_err,
  output logic             wd_en,
  output logic [31:0]      wd_preset,
  output logic             wd_monitor,
  output logic             wd_cnt_pulse,
  input  logic             wd_state,
  input  logic             wd_inactive,
  output logic             frm_valid,
  input  logic             frm_ready,
  output logic [LEN_W-1:0] frm_len,
  output logic             frm_err,
  output logic             frm_ovf,
  output logic             frm_abort
);
  state_e state_q;
  logic [PROD_W-1:0] preset_q;
  logic [DIV_W-1:0] div_q;
  logic [LEN_W-1:0] len_q, pend_len_q, frm_len_q, src_len, add_len;
  logic err_q, ovf_q, pend_err_q, pend_ovf_q, src_err, src_ovf, add_err, add_ovf;
  logic frm_valid_q, frm_err_q, frm_ovf_q, frm_abort_q;
  assign wd_en = state_q != S_OFF;
  assign wd_preset = {{(32 - PROD_W){1'b0}}, preset_q};
  assign wd_monitor = rx_valid & wd_en;
  assign frm_valid = frm_valid_q;
  assign frm_len = frm_len_q;
  assign frm_err = frm_err_q;
  assign frm_ovf = frm_ovf_q;
  assign frm_abort = frm_abort_q;
  // one saturating adder serves the live frame (RECV) and the pending frame (CLOSE)
  assign src_len = (state_q == S_CLOSE) ? pend_len_q : len_q;
  assign src_err = (state_q == S_CLOSE) ? pend_err_q : err_q;
  assign src_ovf = (state_q == S_CLOSE) ? pend_ovf_q : ovf_q;
  assign add_len = (rx_valid && !(&src_len)) ? src_len + 1'b1 : src_len;
  assign add_err = src_err | (rx_valid & rx_err);
  assign add_ovf = src_ovf | (rx_valid & (&src_len));
  uart_frame_ctrl_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk(clk), .rstn(rstn), .en_i(wd_en), .div_i(div_q), .tick_o(wd_cnt_pulse)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_OFF;
      preset_q <= '0;
      div_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      pend_len_q <= '0;
      pend_err_q <= 1'b0;
      pend_ovf_q <= 1'b0;
      frm_valid_q <= 1'b0;
      frm_len_q <= '0;
      frm_err_q <= 1'b0;
      frm_ovf_q <= 1'b0;
      frm_abort_q <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: if (cfg_en) begin
          preset_q <= idle_bits(cfg_idle_chars, cfg_bits_char);
          div_q <= (cfg_baud_div == '0) ? DIV_W'(1) : cfg_baud_div;
          state_q <= S_IDLE;
        end
        S_IDLE: if (!cfg_en) state_q <= S_OFF;
        else if (rx_valid) begin
          len_q <= LEN_W'(1);
          err_q <= rx_err;
          ovf_q <= 1'b0;
          state_q <= S_RECV;
        end
        S_RECV: if (!cfg_en || wd_inactive) begin
          frm_valid_q <= 1'b1;
          frm_len_q <= add_len;
          frm_err_q <= add_err;
          frm_ovf_q <= add_ovf;
          frm_abort_q <= !cfg_en;
          state_q <= S_CLOSE;
        end else begin
          len_q <= add_len;
          err_q <= add_err;
          ovf_q <= add_ovf;
        end
        S_CLOSE: if (!frm_ready) begin
          pend_len_q <= add_len;
          pend_err_q <= add_err;
          pend_ovf_q <= add_ovf;
        end else if (add_len == '0) begin
          frm_valid_q <= 1'b0;
          state_q <= cfg_en ? S_IDLE : S_OFF;
        end else begin
          pend_len_q <= '0;
          pend_err_q <= 1'b0;
          pend_ovf_q <= 1'b0;
          // a still-running burst resumes live counting; an already-idle one becomes the next descriptor
          if (cfg_en && wd_state) begin
            len_q <= add_len;
            err_q <= add_err;
            ovf_q <= add_ovf;
            frm_valid_q <= 1'b0;
            state_q <= S_RECV;
          end else begin
            frm_len_q <= add_len;
            frm_err_q <= add_err;
            frm_ovf_q <= add_ovf;
            frm_abort_q <= !cfg_en;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: self-checking bench with a behavioural watchdog and burst-level frame model
module tb_uart_frame_ctrl;
  localparam int LW = 4;
  localparam int DW = 16;
  localparam int LMAX = (1 << LW) - 1;
  logic clk = 0, rstn = 0, cfg_en = 0;
  logic [DW-1:0] cfg_baud_div = '0;
  logic [3:0] cfg_bits_char = '0;
  logic [7:0] cfg_idle_chars = '0;
  logic rx_valid = 0, rx_err = 0, frm_ready = 0;
  logic wd_en, wd_monitor, wd_cnt_pulse, wd_state, wd_inactive;
  logic frm_valid, frm_err, frm_ovf, frm_abort;
  logic [31:0] wd_preset;
  logic [LW-1:0] frm_len;
  int n_chk = 0, n_fail = 0;
  bit rand_rdy = 0;
  always #5 clk = ~clk;
  uart_frame_ctrl #(.LEN_W(LW), .DIV_W(DW)) dut (
    .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .cfg_baud_div(cfg_baud_div),
    .cfg_bits_char(cfg_bits_char), .cfg_idle_chars(cfg_idle_chars),
    .rx_valid(rx_valid), .rx_err(rx_err), .wd_en(wd_en), .wd_preset(wd_preset),
    .wd_monitor(wd_monitor), .wd_cnt_pulse(wd_cnt_pulse), .wd_state(wd_state),
    .wd_inactive(wd_inactive), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_len(frm_len), .frm_err(frm_err), .frm_ovf(frm_ovf), .frm_abort(frm_abort)
  );
  // watchdog: reload on activity, expire after preset count pulses, report 3 clocks later
  logic [31:0] wcnt;
  logic wact, wst, wexp;
  logic [2:0] dly;
  assign wexp = !wd_monitor && wact && wd_cnt_pulse && wcnt <= 1;
  assign wd_state = wst;
  assign wd_inactive = dly[2];
  always @(posedge clk or negedge rstn) begin
    if (!rstn || !wd_en) begin
      wcnt <= 0; wact <= 0; wst <= 0; dly <= 0;
    end else begin
      dly <= {dly[1:0], wexp};
      if (wd_monitor) begin wcnt <= wd_preset; wact <= 1; wst <= 1; end
      else if (wact && wd_cnt_pulse) begin wcnt <= wcnt - 1; if (wexp) wact <= 0; end
      if (dly[1] && !wd_monitor && !wact) wst <= 0;
    end
  end
  typedef struct {int len; bit err; bit ovf; bit abort;} desc_t;
  desc_t got[$];
  desc_t exp_q[$];
  always @(negedge clk)
    if (rstn && frm_valid && frm_ready) got.push_back('{int'(frm_len), frm_err, frm_ovf, frm_abort});
  typedef struct {int div; int bits; int idle; int n; int gap; int errmask; int exp_preset; int exp_len; bit exp_err; bit exp_ovf;} vec_t;
  vec_t tbl[5];
  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rdy) frm_ready = $urandom_range(0, 3) != 0;
    end
  endtask
  task automatic send_byte(input bit e);
    rx_valid = 1; rx_err = e;
    step();
    rx_valid = 0; rx_err = 0;
  endtask
  task automatic configure(input int div, input int bits, input int idle);
    cfg_en = 0;
    step(2);
    cfg_baud_div = DW'(div); cfg_bits_char = 4'(bits); cfg_idle_chars = 8'(idle);
    cfg_en = 1;
    step(2);
  endtask
  task automatic wait_desc(input int limit, output int lat);
    lat = 0;
    while (lat < limit && got.size() == 0) begin step(); lat++; end
  endtask
  task automatic expect_desc(input string nm, input desc_t e);
    desc_t d;
    check({nm, "_present"}, got.size() > 0, 1);
    if (got.size() > 0) begin
      d = got.pop_front();
      check({nm, "_len"}, d.len, e.len);
      check({nm, "_err"}, d.err, e.err);
      check({nm, "_ovf"}, d.ovf, e.ovf);
      check({nm, "_abort"}, d.abort, e.abort);
    end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end
  initial begin
    int lat, dive, pr, cnt, unstable, cap, n;
    bit e, errs, seen;
    tbl[0] = '{4, 10, 2, 5, 40, 'h0, 20, 5, 1'b0, 1'b0};
    tbl[1] = '{4, 10, 2, 5, 10, 'h4, 20, 5, 1'b1, 1'b0};
    tbl[2] = '{1, 4, 3, 20, 3, 'h0, 12, 15, 1'b0, 1'b1};
    tbl[3] = '{0, 2, 1, 3, 1, 'h1, 2, 3, 1'b1, 1'b0};
    tbl[4] = '{2, 15, 255, 2, 5, 'h0, 3825, 2, 1'b0, 1'b0};
    rx_valid = 1;
    #3;
    check("rst_wd_en", wd_en, 0);
    check("rst_wd_monitor", wd_monitor, 0);
    check("rst_wd_preset", wd_preset, 0);
    check("rst_frm_valid", frm_valid, 0);
    check("rst_cnt_pulse", wd_cnt_pulse, 0);
    rx_valid = 0;
    step(2);
    rstn = 1;
    frm_ready = 1;
    step(2);
    for (int i = 0; i < 5; i++) begin
      configure(tbl[i].div, tbl[i].bits, tbl[i].idle);
      check($sformatf("v%0d_preset", i), wd_preset, tbl[i].exp_preset);
      check($sformatf("v%0d_wd_en", i), wd_en, 1);
      for (int j = 0; j < tbl[i].n; j++) begin
        send_byte(1'((tbl[i].errmask >> j) & 1));
        if (j < tbl[i].n - 1) step(tbl[i].gap - 1);
      end
      dive = tbl[i].div == 0 ? 1 : tbl[i].div;
      wait_desc(tbl[i].exp_preset * dive + 40, lat);
      check($sformatf("v%0d_lat_lo", i), lat >= (tbl[i].exp_preset - 1) * dive, 1);
      check($sformatf("v%0d_lat_hi", i), lat <= tbl[i].exp_preset * dive + 8, 1);
      expect_desc($sformatf("v%0d", i), '{tbl[i].exp_len, tbl[i].exp_err, tbl[i].exp_ovf, 1'b0});
    end
    configure(4, 10, 2);
    cnt = 0;
    repeat (40) begin @(negedge clk); cnt += int'(wd_cnt_pulse); end
    check("pulse_div4", cnt, 10);
    configure(0, 2, 2);
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += int'(wd_cnt_pulse); end
    check("pulse_div0", cnt, 10);
    step();
    // backpressure: second burst must queue behind the held first descriptor
    configure(1, 4, 2);
    frm_ready = 0;
    send_byte(0); step(1); send_byte(1);
    lat = 0;
    while (lat < 60 && !frm_valid) begin step(); lat++; end
    check("bp_first_valid", frm_valid, 1);
    cap = int'(frm_len);
    check("bp_first_len", cap, 2);
    unstable = 0;
    for (int j = 0; j < 3; j++) begin
      send_byte(0);
      if (!frm_valid || int'(frm_len) != cap || !frm_err) unstable++;
      step(1);
    end
    repeat (40) begin
      step();
      if (!frm_valid || int'(frm_len) != cap || !frm_err) unstable++;
    end
    check("bp_hold_stable", unstable, 0);
    frm_ready = 1;
    step();
    frm_ready = 0;
    expect_desc("bp_a", '{2, 1'b1, 1'b0, 1'b0});
    check("bp_b_valid", frm_valid, 1);
    check("bp_b_len", frm_len, 3);
    frm_ready = 1;
    step();
    expect_desc("bp_b", '{3, 1'b0, 1'b0, 1'b0});
    step(2);
    check("bp_done", frm_valid, 0);
    configure(2, 4, 2);
    for (int j = 0; j < 4; j++) begin send_byte(0); step(1); end
    cfg_en = 0;
    wait_desc(20, lat);
    expect_desc("abort", '{4, 1'b0, 1'b0, 1'b1});
    step(2);
    check("abort_wd_en", wd_en, 0);
    check("abort_valid", frm_valid, 0);
    configure(1, 2, 2);
    send_byte(0); send_byte(0);
    seen = 0;
    for (int j = 0; j < 30 && !seen; j++) begin step(); seen = wd_inactive; end
    check("coinc_seen", seen, 1);
    send_byte(0);
    wait_desc(10, lat);
    expect_desc("coinc", '{3, 1'b0, 1'b0, 1'b0});
    step(30);
    check("coinc_no_extra", got.size(), 0);
    configure(2, 4, 2);
    send_byte(0); step(1); send_byte(0);
    rx_valid = 1;
    #2 rstn = 0;
    #1;
    check("mid_rst_wd_en", wd_en, 0);
    check("mid_rst_monitor", wd_monitor, 0);
    check("mid_rst_preset", wd_preset, 0);
    check("mid_rst_pulse", wd_cnt_pulse, 0);
    check("mid_rst_valid", frm_valid, 0);
    rx_valid = 0;
    step(2);
    rstn = 1;
    configure(2, 4, 2);
    step(60);
    check("post_rst_no_desc", got.size() + int'(frm_valid), 0);
    for (int r = 0; r < 3; r++) begin
      dive = $urandom_range(0, 3);
      configure(dive, $urandom_range(2, 4), $urandom_range(2, 3));
      dive = dive == 0 ? 1 : dive;
      pr = int'(wd_preset);
      rand_rdy = 1;
      for (int b = 0; b < 12; b++) begin
        n = $urandom_range(1, 20);
        errs = 0;
        for (int j = 0; j < n; j++) begin
          e = ($urandom_range(0, 9) == 0);
          errs |= e;
          send_byte(e);
          if (j < n - 1) step($urandom_range(0, (pr - 1) * dive - 1));
        end
        exp_q.push_back('{n > LMAX ? LMAX : n, errs, n > LMAX, 1'b0});
        step(pr * dive + 20);
      end
      rand_rdy = 0;
      frm_ready = 1;
      step(10);
      check($sformatf("rand%0d_count", r), got.size(), exp_q.size());
      while (exp_q.size() > 0) expect_desc($sformatf("rand%0d", r), exp_q.pop_front());
      got.delete();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
